// File: rtl/axi_decerr_pkg.sv
// ----------------------------------------------------------------------------
// axi_decerr_pkg
//
// Shared types and constants for the AXI4 decode-error responder.
//   wr_state_e           : write-path FSM states.
//   rd_state_e           : read-path FSM states.
//   RESP_DECERR/SLVERR   : AXI response encodings.
//   DEFAULT_DATA_PATTERN : constant read data returned on every R beat.
// ----------------------------------------------------------------------------
package axi_decerr_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   localparam logic [1:0]  RESP_DECERR          = 2'b11;
   localparam logic [1:0]  RESP_SLVERR          = 2'b10;
   localparam logic [63:0] DEFAULT_DATA_PATTERN = 64'hCA11_AB1E_BADC_AB1E;

endpackage : axi_decerr_pkg

// File: rtl/axi_decerr_rd_chan.sv
// ----------------------------------------------------------------------------
// axi_decerr_rd_chan
//
// Read-path FSM of the decode-error responder. Accepts one AR at a time and
// returns ar_len_i+1 R beats, flagging the final one with r_last_o.
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset.
//   ar_valid_i / ar_ready_o  : read address handshake.
//   ar_id_i, ar_len_i        : request ID and burst length (beats - 1).
//   r_valid_o / r_ready_i    : read data handshake.
//   r_id_o, r_last_o         : ID echoed back, last-beat flag.
// ----------------------------------------------------------------------------
module axi_decerr_rd_chan
   import axi_decerr_pkg::*;
#(
   parameter int unsigned ID_WIDTH = 6
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ar_valid_i,
   output logic                ar_ready_o,
   input  logic [ID_WIDTH-1:0] ar_id_i,
   input  logic [7:0]          ar_len_i,
   output logic                r_valid_o,
   input  logic                r_ready_i,
   output logic [ID_WIDTH-1:0] r_id_o,
   output logic                r_last_o
);

   rd_state_e           rd_state_d, rd_state_q;
   logic [ID_WIDTH-1:0] r_id_d, r_id_q;
   logic [7:0]          beat_cnt_d, beat_cnt_q;

   // NOTE: every variable assigned here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      rd_state_d = rd_state_q;
      r_id_d     = r_id_q;
      beat_cnt_d = beat_cnt_q;
      unique case (rd_state_q)
         R_IDLE: begin
            if (ar_valid_i) begin
               r_id_d     = ar_id_i;
               beat_cnt_d = ar_len_i;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (r_ready_i) begin
               // The counter is only decremented while non-zero, so it can
               // never wrap below 0 on the last beat.
               if (beat_cnt_q == 8'd0) begin
                  rd_state_d = R_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q - 8'd1;
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_state_q <= R_IDLE;
         r_id_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         r_id_q     <= r_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Handshake outputs decode straight from state, so an asynchronous reset
   // drops r_valid_o immediately.
   assign ar_ready_o = (rd_state_q == R_IDLE);
   assign r_valid_o  = (rd_state_q == R_DATA);
   assign r_last_o   = (rd_state_q == R_DATA) && (beat_cnt_q == 8'd0);
   assign r_id_o     = r_id_q;

endmodule : axi_decerr_rd_chan

// File: rtl/axi_decerr_responder.sv
// ----------------------------------------------------------------------------
// axi_decerr_responder
//
// AXI4 terminal slave for unmapped address space. Every write and read is
// completed legally with a DECERR response carrying the request ID. Address,
// size, burst, strobe and write data are ignored.
//
// Build option: define AXI_DECERR_COUNT_EN to enable the saturating error
// transaction counter on err_count_o; otherwise err_count_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni                         : clock, async active-low reset.
//   aw_valid_i/aw_ready_o/aw_id_i         : write address channel.
//   w_valid_i/w_ready_o/w_last_i          : write data channel (no payload).
//   b_valid_o/b_ready_i/b_id_o/b_resp_o   : write response channel.
//   ar_valid_i/ar_ready_o/ar_id_i/ar_len_i: read address channel.
//   r_valid_o/r_ready_i/r_id_o/r_data_o/
//   r_resp_o/r_last_o                     : read data channel.
//   err_count_o                           : completed error transactions.
// ----------------------------------------------------------------------------
module axi_decerr_responder
   import axi_decerr_pkg::*;
#(
   parameter int unsigned ID_WIDTH     = 6,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter logic [1:0]  RESP_CODE    = RESP_DECERR,
   parameter logic [63:0] DATA_PATTERN = DEFAULT_DATA_PATTERN
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  aw_valid_i,
   output logic                  aw_ready_o,
   input  logic [ID_WIDTH-1:0]   aw_id_i,
   input  logic                  w_valid_i,
   output logic                  w_ready_o,
   input  logic                  w_last_i,
   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   output logic [ID_WIDTH-1:0]   b_id_o,
   output logic [1:0]            b_resp_o,
   input  logic                  ar_valid_i,
   output logic                  ar_ready_o,
   input  logic [ID_WIDTH-1:0]   ar_id_i,
   input  logic [7:0]            ar_len_i,
   output logic                  r_valid_o,
   input  logic                  r_ready_i,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   output logic [15:0]           err_count_o
);

   // ---------------------------------------------------------------- write
   wr_state_e           wr_state_d, wr_state_q;
   logic [ID_WIDTH-1:0] b_id_d, b_id_q;

   always_comb begin
      wr_state_d = wr_state_q;
      b_id_d     = b_id_q;
      unique case (wr_state_q)
         W_IDLE: begin
            if (aw_valid_i) begin
               b_id_d     = aw_id_i;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_valid_i && w_last_i) wr_state_d = W_RESP;
         end
         W_RESP: begin
            if (b_ready_i) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_state_q <= W_IDLE;
         b_id_q     <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         b_id_q     <= b_id_d;
      end
   end

   // W beats are only accepted after their AW, which stalls early data.
   assign aw_ready_o = (wr_state_q == W_IDLE);
   assign w_ready_o  = (wr_state_q == W_DATA);
   assign b_valid_o  = (wr_state_q == W_RESP);
   assign b_id_o     = b_id_q;
   assign b_resp_o   = RESP_CODE;

   // ----------------------------------------------------------------- read
   axi_decerr_rd_chan #(
      .ID_WIDTH (ID_WIDTH)
   ) u_rd_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .ar_valid_i (ar_valid_i),
      .ar_ready_o (ar_ready_o),
      .ar_id_i    (ar_id_i),
      .ar_len_i   (ar_len_i),
      .r_valid_o  (r_valid_o),
      .r_ready_i  (r_ready_i),
      .r_id_o     (r_id_o),
      .r_last_o   (r_last_o)
   );

   assign r_data_o = DATA_WIDTH'(DATA_PATTERN);
   assign r_resp_o = RESP_CODE;

   // ---------------------------------------------------------- error count
`ifdef AXI_DECERR_COUNT_EN
   logic [15:0] err_count_d, err_count_q;
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   // A B handshake and a last R handshake may coincide: add both, then
   // clamp using the carry out of the 17-bit sum.
   always_comb begin
      err_inc     = {1'b0, b_valid_o & b_ready_i}
                  + {1'b0, r_valid_o & r_ready_i & r_last_o};
      err_sum     = {1'b0, err_count_q} + {15'd0, err_inc};
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count_o = err_count_q;
`else
   assign err_count_o = 16'h0;
`endif

endmodule : axi_decerr_responder

// File: doc/axi_decerr_responder.md
Name: axi_decerr_responder

Overview:
- AXI4 terminal responder on a crossbar master port: the default slave for addresses matching no rule in the SoC address map (e.g. 0x6000_0000, holes between peripherals).
- Completes every write and read legally, returning DECERR with the request ID, so the CVA6, debug and VGA DMA masters never hang on unmapped accesses.
- Address, size, burst, strobe and data payloads are ignored; only IDs, read length and last flags matter.

Parameters:
- ID_WIDTH, 6, slave-side AXI ID width (4 master ID bits + 2 crossbar bits).
- DATA_WIDTH, 64, R data width.
- RESP_CODE, 2'b11, response driven on B and R (DECERR).
- DATA_PATTERN, 64'hCA11_AB1E_BADC_AB1E, constant R data, truncated to DATA_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- aw_valid_i  in  1  / aw_ready_o  out  1 / aw_id_i  in  ID_WIDTH: write address channel.
- w_valid_i  in  1 / w_ready_o  out  1 / w_last_i  in  1: write data channel (data and strb not connected).
- b_valid_o  out  1 / b_ready_i  in  1 / b_id_o  out  ID_WIDTH / b_resp_o  out  2: write response.
- ar_valid_i  in  1 / ar_ready_o  out  1 / ar_id_i  in  ID_WIDTH / ar_len_i  in  8: read address.
- r_valid_o  out  1 / r_ready_i  in  1 / r_id_o  out  ID_WIDTH / r_data_o  out  DATA_WIDTH / r_resp_o  out  2 / r_last_o  out  1: read data.
- err_count_o  out  16  error transaction count (see Optional Feature).

Behaviour:
- Write and read paths are independent FSMs. Both may handshake in the same cycle. All outputs are registered or decoded directly from state.
- Reset values:
  - aw_ready_o=1, ar_ready_o=1.
  - w_ready_o, b_valid_o, r_valid_o, r_last_o = 0.
  - IDs = 0, err_count_o = 0.
  - b_resp_o/r_resp_o = RESP_CODE, r_data_o = DATA_PATTERN (both constant).
- Write FSM:
  - W_IDLE: aw_ready_o=1. On AW handshake, latch aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Consume beats; on a W handshake with w_last_i=1, go to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o = latched ID, held stable until b_ready_i. On the handshake, go to W_IDLE.
- Write latencies: AW handshake at cycle N gives w_ready_o at N+1. Last W handshake at M gives b_valid_o at M+1. After a B handshake, aw_ready_o=1 in the next cycle.
- W beats arriving before AW are stalled (w_ready_o=0 outside W_DATA). One write is outstanding at a time.
- Read FSM:
  - R_IDLE: ar_ready_o=1. On AR handshake, latch ar_id_i, load beat counter = ar_len_i, go to R_DATA.
  - R_DATA: r_valid_o=1, r_last_o = (counter==0). Each R handshake decrements the counter. A handshake with r_last_o=1 returns to R_IDLE.
- Read latencies: AR handshake at N gives first r_valid_o at N+1. With r_ready_i held high, one beat per cycle and exactly ar_len_i+1 beats.
- r_ready_i low: r_valid_o, r_last_o, r_id_o hold. The counter holds. No valid is dropped before its handshake.
- ar_len_i=0: single beat with r_last_o=1. ar_len_i=255: 256 beats; the 8-bit counter does not wrap below 0.
- Reset asserted mid-burst: both FSMs return to IDLE immediately and all valids drop asynchronously. Partial bursts are discarded.

Optional Feature:
- Macro: AXI_DECERR_COUNT_EN.
- Defined: err_count_o increments by 1 on each B handshake and each R handshake with r_last_o=1. It saturates at 16'hFFFF. If both occur in the same cycle it increments by 2, saturating.
- Not defined: err_count_o is tied to 16'h0 and no counter flops are inferred.

Decomposition:
- Package axi_decerr_pkg holds:
  - wr_state_e {W_IDLE, W_DATA, W_RESP};
  - rd_state_e {R_IDLE, R_DATA};
  - localparam RESP_DECERR=2'b11, RESP_SLVERR=2'b10;
  - the default DATA_PATTERN constant.
- One natural sub-module: axi_decerr_rd_chan, containing the read FSM and beat counter. The write FSM stays inline in the top.

Test Plan:
- AW id=6'h15, then W 4 beats (last on beat 4) -> w_ready 1 cycle after AW; b_valid 1 cycle after last W; b_id=6'h15, b_resp=2'b11.
- AR id=6'h2A, len=3, r_ready=1 -> 4 beats on consecutive cycles; r_data=64'hCA11AB1EBADCAB1E; r_last only on beat 4; r_id=6'h2A.
- AR len=7 with r_ready toggling every other cycle -> exactly 8 handshakes; outputs stable while stalled; ar_ready=0 until the last handshake.
- W presented 5 cycles before AW -> w_ready=0 throughout; after AW (id=1), W accepted; B returned with id=1.
- Simultaneous AW(id=3) and AR(id=4, len=0) in one cycle -> both accepted; B id=3 and single R beat id=4 with r_last=1. With AXI_DECERR_COUNT_EN, err_count_o=2.
- rst_ni pulsed low during beat 2 of a len=15 read -> r_valid=0 immediately; ar_ready=1 after release; err_count_o=0.
